gray_counter_ext: RTL and testbench

Parametrised up/down Gray-code counter. It is the successor to the fixed-function Gray counter, adding count enable, saturate/wrap mode, Gray-coded parallel load and boundary flags. The registered Gray output is always the exact encoding of the registered binary count, with no one-cycle lag. It is used as a source of single-bit-change pointers and position codes for CDC and encoder-emulation logic on a single clock domain.

---
 rtl/gray_counter_ext.sv | 108 ++++++++++
 tb/tb_gray_counter_ext.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_ext.sv
// gray_counter_ext: parametrised up/down Gray-code counter with count enable,
// saturate/wrap selection, Gray-coded parallel load and boundary flags.
// The binary count is the only real state. The Gray output is registered from
// the same next-state value, so o_gray always encodes o_bin with no lag.
module gray_counter_ext #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RST_VALUE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_sat,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_gray,
  output logic [WIDTH-1:0] o_gray,
  output logic [WIDTH-1:0] o_bin,
  output logic             o_wrap,
  output logic             o_at_limit
);

  // Boundary and reset constants, all exactly WIDTH bits wide.
  localparam logic [WIDTH-1:0] MAX_BIN  = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_BIN  = RST_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  // Binary to reflected Gray code.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_d;

  logic             at_max;
  logic             at_zero;

  assign at_max  = (bin_q == MAX_BIN);
  assign at_zero = (bin_q == '0);

  // Next binary count and wrap pulse: load beats count, count beats hold.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (i_load) begin
      bin_d = gray2bin(i_load_gray);
    end else if (i_en) begin
      if (i_dir) begin
        if (!at_max) begin
          bin_d = bin_q + ONE;
        end else if (!i_sat) begin
          bin_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          bin_d = bin_q - ONE;
        end else if (!i_sat) begin
          bin_d  = MAX_BIN;
          wrap_d = 1'b1;
        end
      end
    end
  end

  // Gray is encoded from the next binary value so both registers load together.
  assign gray_d = bin2gray(bin_d);

  // State registers; reset is asynchronous and overrides any load or count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_bin      = bin_q;
  assign o_gray     = gray_q;
  assign o_wrap     = wrap_q;
  // Limit flag looks only at the current count and the requested direction.
  assign o_at_limit = i_dir ? at_max : at_zero;

endmodule

// File: tb/tb_gray_counter_ext.sv
// Testbench for gray_counter_ext (WIDTH=4, RST_VALUE=5).
// A driver issues one vector per clock and pushes the expected response into a
// scoreboard queue; a monitor pops and compares after every rising edge.
module tb_gray_counter_ext;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
    logic         lim;
    logic         chk_ham;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         dir;
  logic         sat;
  logic         load;
  logic [W-1:0] load_gray;
  logic [W-1:0] o_gray;
  logic [W-1:0] o_bin;
  logic         o_wrap;
  logic         o_at_limit;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Reference model state for the randomised phase.
  int   model_bin;

  gray_counter_ext #(.WIDTH(W), .RST_VALUE(5)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_dir      (dir),
    .i_sat      (sat),
    .i_load     (load),
    .i_load_gray(load_gray),
    .o_gray     (o_gray),
    .o_bin      (o_bin),
    .o_wrap     (o_wrap),
    .o_at_limit (o_at_limit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Drive one vector on the falling edge and queue the response expected
  // after the following rising edge.
  task automatic step(input logic l, input logic [W-1:0] lg, input logic e,
                      input logic d, input logic s, input logic [W-1:0] xbin,
                      input logic [W-1:0] xgray, input logic xwrap,
                      input logic ham);
    exp_t r;
    @(negedge clk);
    load = l; load_gray = lg; en = e; dir = d; sat = s;
    r.bin     = xbin;
    r.gray    = xgray;
    r.wrap    = xwrap;
    r.lim     = (d && xbin == 4'd15) || (!d && xbin == 4'd0);
    r.chk_ham = ham;
    sb_q.push_back(r);
  endtask

  // Wait (bounded) for the monitor to consume every queued expectation.
  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 8) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("scoreboard_drain", sb_q.size(), 0);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation.
  initial begin : monitor
    exp_t         r;
    logic [W-1:0] prev_dut_gray;
    logic [W-1:0] prev_exp_gray;
    prev_dut_gray = '0;
    prev_exp_gray = '0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        r = sb_q.pop_front();
        check("bin",  o_bin, r.bin);
        check("gray", o_gray, r.gray);
        check("wrap", o_wrap, r.wrap);
        check("at_limit", o_at_limit, r.lim);
        if (r.chk_ham)
          check("gray_hamming", $countones(o_gray ^ prev_dut_gray),
                $countones(r.gray ^ prev_exp_gray));
        prev_dut_gray = o_gray;
        prev_exp_gray = r.gray;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic         r_load, r_en, r_dir, r_sat, r_wrap;
    logic [W-1:0] r_lg;

    rst_n = 1'b0; en = 1'b0; dir = 1'b1; sat = 1'b0; load = 1'b0; load_gray = '0;

    // Reset values while held in reset.
    #12;
    check("reset_bin",  o_bin, 4'd5);
    check("reset_gray", o_gray, 4'b0111);
    check("reset_wrap", o_wrap, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    // First cycle after release, idle: value held.
    step(0, 4'b0000, 0, 1, 0, 4'd5, 4'b0111, 0, 0);

    // Load zero, then count up with wrap for 20 cycles.
    step(1, 4'b0000, 0, 1, 0, 4'd0, 4'b0000, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      logic [W-1:0] b;
      b = 4'(i % 16);
      step(0, 4'b0000, 1, 1, 0, b, (b == 4'd15) ? 4'b1000 : b2g(b), (i == 16), 1);
    end

    // Load 2 (Gray 0011), then count down saturating.
    step(1, 4'b0011, 0, 0, 1, 4'd2, 4'b0011, 0, 0);
    step(0, 4'b0000, 1, 0, 1, 4'd1, 4'b0001, 0, 1);
    step(0, 4'b0000, 1, 0, 1, 4'd0, 4'b0000, 0, 1);
    step(0, 4'b0000, 1, 0, 1, 4'd0, 4'b0000, 0, 1);
    step(0, 4'b0000, 1, 0, 1, 4'd0, 4'b0000, 0, 1);
    step(0, 4'b0000, 1, 0, 1, 4'd0, 4'b0000, 0, 1);

    // Load wins over an enabled count in the same cycle.
    step(1, 4'b1101, 1, 1, 0, 4'd9, 4'b1101, 0, 0);

    // Down wrap from zero to MAX.
    step(1, 4'b0000, 0, 0, 0, 4'd0, 4'b0000, 0, 0);
    step(0, 4'b0000, 1, 0, 0, 4'd15, 4'b1000, 1, 1);
    step(0, 4'b0000, 1, 0, 0, 4'd14, 4'b1001, 0, 1);

    // Up saturation at MAX, then idle with the limit flag following i_dir.
    step(1, 4'b1000, 0, 1, 1, 4'd15, 4'b1000, 0, 0);
    step(0, 4'b0000, 1, 1, 1, 4'd15, 4'b1000, 0, 1);
    step(0, 4'b0000, 1, 1, 1, 4'd15, 4'b1000, 0, 1);
    step(0, 4'b0000, 0, 0, 1, 4'd15, 4'b1000, 0, 1);

    // Count from 3 then assert reset between edges.
    step(1, 4'b0010, 0, 1, 0, 4'd3, 4'b0010, 0, 0);
    step(0, 4'b0000, 1, 1, 0, 4'd4, 4'b0110, 0, 1);
    step(0, 4'b0000, 1, 1, 0, 4'd5, 4'b0111, 0, 1);
    step(0, 4'b0000, 1, 1, 0, 4'd6, 4'b0101, 0, 1);
    drain();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_bin",  o_bin, 4'd5);
    check("async_reset_gray", o_gray, 4'b0111);
    check("async_reset_wrap", o_wrap, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold_bin",  o_bin, 4'd5);
    check("reset_hold_gray", o_gray, 4'b0111);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    step(0, 4'b0000, 1, 1, 0, 4'd6, 4'b0101, 0, 0);

    // Randomised phase against a behavioural model.
    model_bin = 6;
    for (int i = 0; i < 80; i++) begin
      r_load = ($urandom_range(0, 7) == 0);
      r_lg   = 4'($urandom_range(0, 15));
      r_en   = ($urandom_range(0, 3) != 0);
      r_dir  = 1'($urandom_range(0, 1));
      r_sat  = 1'($urandom_range(0, 1));
      r_wrap = 1'b0;
      if (r_load) begin
        model_bin = int'(g2b(r_lg));
      end else if (r_en) begin
        if (r_dir) begin
          if (model_bin < 15) model_bin = model_bin + 1;
          else if (!r_sat) begin model_bin = 0; r_wrap = 1'b1; end
        end else begin
          if (model_bin > 0) model_bin = model_bin - 1;
          else if (!r_sat) begin model_bin = 15; r_wrap = 1'b1; end
        end
      end
      step(r_load, r_lg, r_en, r_dir, r_sat, 4'(model_bin),
           b2g(4'(model_bin)), r_wrap, !r_load);
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
